// File: rtl/seg_disp_pkg.sv
// Shared segment codes, BCD-to-7-seg lookup and controller state encoding
// for the scanned time/date display decoder.
package seg_disp_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {IDLE, CONV, STORE, COMMIT} state_t;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_bin2bcd.sv
// Iterative shift-add-3 binary to two-digit BCD converter, one bit per cycle.
// ovf flags a carry out of the tens digit, i.e. an input value above 99.
module bin2bcd_seq #(
  parameter int unsigned FIELD_W = 7
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               start,
  input  logic [FIELD_W-1:0] bin,
  output logic               done,
  output logic [7:0]         bcd,
  output logic               ovf
);

  localparam int unsigned CW = $clog2(FIELD_W + 1);

  logic [FIELD_W-1:0] sh_q;
  logic [7:0]         bcd_q;
  logic [CW-1:0]      cnt_q;
  logic               ovf_q;
  logic [7:0]         adj;

  always_comb begin
    adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (start) begin
      sh_q  <= bin;
      bcd_q <= '0;
      cnt_q <= CW'(FIELD_W);
      ovf_q <= 1'b0;
    end else if (cnt_q != '0) begin
      bcd_q <= {adj[6:0], sh_q[FIELD_W-1]};
      sh_q  <= {sh_q[FIELD_W-2:0], 1'b0};
      ovf_q <= ovf_q | adj[7];
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // done marks the final shift cycle; bcd/ovf are valid from the next cycle
  assign done = (cnt_q == CW'(1));
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg_scan_decoder.sv
// Multi-field binary to 7-segment display decoder: one shared BCD converter,
// atomic shadow->display commit, parallel bus plus scanned output with blink.
module seg_scan_decoder
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_FIELDS = 3,
  parameter int unsigned FIELD_W    = 7,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLINK_DIV  = 250
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic [NUM_FIELDS*FIELD_W-1:0] IN_FIELDS,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [NUM_FIELDS-1:0]         BLINK_MASK,
  output logic [16*NUM_FIELDS-1:0]      OUT_SEG_ALL,
  output logic [7:0]                    OUT_SEG,
  output logic [2*NUM_FIELDS-1:0]       OUT_COM
);

  localparam int unsigned NDIG   = 2 * NUM_FIELDS;
  localparam int unsigned DW     = 16 * NUM_FIELDS;
  localparam int unsigned FIDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned DIG_W  = $clog2(NDIG);
  localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DW-1:0] DISP_RST = {NDIG{SEG_0}};

  state_t                        state, state_nx;
  logic [FIDX_W-1:0]             fidx, fidx_nx;
  logic [NUM_FIELDS*FIELD_W-1:0] fields_q;
  logic [DW-1:0]                 shadow_q, disp_q;
  logic                          last_field;
  logic [15:0]                   store_codes;

  logic               conv_start, conv_done, conv_ovf;
  logic [FIELD_W-1:0] conv_bin;
  logic [7:0]         conv_bcd;

  bin2bcd_seq #(.FIELD_W(FIELD_W)) u_bin2bcd (
    .CLK    (CLK),
    .RESETN (RESETN),
    .start  (conv_start),
    .bin    (conv_bin),
    .done   (conv_done),
    .bcd    (conv_bcd),
    .ovf    (conv_ovf)
  );

  // Field 0 is started straight from IN_FIELDS since the latch loads on the same edge
  always_comb begin
    state_nx   = state;
    fidx_nx    = fidx;
    conv_start = 1'b0;
    conv_bin   = IN_FIELDS[FIELD_W-1:0];
    last_field = (fidx == FIDX_W'(NUM_FIELDS - 1));
    case (state)
      IDLE: begin
        if (IN_VALID) begin
          conv_start = 1'b1;
          fidx_nx    = '0;
          state_nx   = CONV;
        end
      end
      CONV: begin
        if (conv_done) state_nx = STORE;
      end
      STORE: begin
        if (last_field) begin
          state_nx = COMMIT;
        end else begin
          fidx_nx    = fidx + FIDX_W'(1);
          conv_start = 1'b1;
          conv_bin   = fields_q[int'(fidx_nx)*FIELD_W +: FIELD_W];
          state_nx   = CONV;
        end
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign store_codes = conv_ovf ? {SEG_DASH, SEG_DASH}
                                : {bcd_to_seg(conv_bcd[7:4]), bcd_to_seg(conv_bcd[3:0])};

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      fidx     <= '0;
      fields_q <= '0;
      shadow_q <= DISP_RST;
      disp_q   <= DISP_RST;
    end else begin
      state <= state_nx;
      fidx  <= fidx_nx;
      if (state == IDLE && IN_VALID) fields_q <= IN_FIELDS;
      if (state == STORE) shadow_q[int'(fidx)*16 +: 16] <= store_codes;
      if (state == COMMIT) disp_q <= shadow_q;
    end
  end

  assign IN_READY    = (state == IDLE);
  assign OUT_SEG_ALL = disp_q;

  logic [PRE_W-1:0]  pre_q;
  logic [DIG_W-1:0]  dig_q, dig_nx;
  logic [BLK_W-1:0]  bcnt_q, bcnt_nx;
  logic              phase_q, phase_nx;
  logic              scan_wrap;
  logic [FIDX_W-1:0] fsel;
  logic [DW-1:0]     seg_src;
  logic [7:0]        seg_nx;

  // Scan output looks one step ahead and reads shadow during COMMIT, so a
  // commit landing on a scan step never shows a torn digit pair
  always_comb begin
    scan_wrap = (pre_q == PRE_W'(SCAN_DIV - 1));
    dig_nx    = dig_q;
    bcnt_nx   = bcnt_q;
    phase_nx  = phase_q;
    if (scan_wrap) begin
      dig_nx = (dig_q == DIG_W'(NDIG - 1)) ? '0 : dig_q + DIG_W'(1);
      if (bcnt_q == BLK_W'(BLINK_DIV - 1)) begin
        bcnt_nx  = '0;
        phase_nx = ~phase_q;
      end else begin
        bcnt_nx = bcnt_q + BLK_W'(1);
      end
    end
    fsel    = FIDX_W'(dig_nx >> 1);
    seg_src = (state == COMMIT) ? shadow_q : disp_q;
    seg_nx  = seg_src[int'(fsel)*16 + (dig_nx[0] ? 0 : 8) +: 8];
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pre_q   <= '0;
      dig_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      OUT_COM <= NDIG'(1);
      OUT_SEG <= SEG_BLANK;
    end else begin
      pre_q   <= scan_wrap ? '0 : pre_q + PRE_W'(1);
      dig_q   <= dig_nx;
      bcnt_q  <= bcnt_nx;
      phase_q <= phase_nx;
      OUT_COM <= NDIG'(1) << dig_nx;
      OUT_SEG <= (phase_nx && BLINK_MASK[fsel]) ? SEG_BLANK : seg_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with short scan/blink dividers.
module tb_seg_scan_decoder;

  localparam int NF = 3;
  localparam int FW = 7;
  localparam int SD = 4;
  localparam int BD = 2;

  logic           CLK = 1'b0;
  logic           RESETN;
  logic [NF*FW-1:0] IN_FIELDS;
  logic           IN_VALID;
  logic           IN_READY;
  logic [NF-1:0]  BLINK_MASK;
  logic [16*NF-1:0] OUT_SEG_ALL;
  logic [7:0]     OUT_SEG;
  logic [2*NF-1:0] OUT_COM;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [47:0] disp_exp;

  localparam logic [47:0] ALL_ZERO = 48'h3F3F_3F3F_3F3F;

  seg_scan_decoder #(
    .NUM_FIELDS (NF),
    .FIELD_W    (FW),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .IN_FIELDS   (IN_FIELDS),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .BLINK_MASK  (BLINK_MASK),
    .OUT_SEG_ALL (OUT_SEG_ALL),
    .OUT_SEG     (OUT_SEG),
    .OUT_COM     (OUT_COM)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (RESETN) cyc++;
  endtask

  // Scan model: cyc edges since reset release, SD edges per digit step
  function automatic logic [5:0] exp_com();
    int d;
    d = (cyc / SD) % (2 * NF);
    return 6'd1 << d;
  endfunction

  function automatic logic [7:0] exp_seg();
    int steps, d, ph, f;
    steps = cyc / SD;
    d  = steps % (2 * NF);
    ph = (steps / BD) % 2;
    f  = d / 2;
    if (ph == 1 && BLINK_MASK[f]) return 8'h00;
    return (d % 2 == 0) ? disp_exp[16*f + 8 +: 8] : disp_exp[16*f +: 8];
  endfunction

  task automatic check_scan(input string tag);
    check({tag, "_com"}, 64'(OUT_COM), 64'(exp_com()));
    check({tag, "_seg"}, 64'(OUT_SEG), 64'(exp_seg()));
  endtask

  task automatic transfer(input string tag, input logic [NF*FW-1:0] v,
                          input logic [47:0] exp_new, input bit intrude);
    int n;
    IN_FIELDS = v;
    IN_VALID  = 1'b1;
    check({tag, "_ready_before"}, 64'(IN_READY), 64'd1);
    tick();
    IN_VALID = 1'b0;
    check({tag, "_ready_busy"}, 64'(IN_READY), 64'd0);
    n = 0;
    while (IN_READY !== 1'b1 && n < 100) begin
      if (intrude && n == 3) begin
        IN_FIELDS = {7'd1, 7'd1, 7'd1};
        IN_VALID  = 1'b1;
      end
      if (intrude && n == 5) IN_VALID = 1'b0;
      if (n == 24) check({tag, "_disp_before_commit"}, 64'(OUT_SEG_ALL), 64'(disp_exp));
      tick();
      n++;
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'd25);
    disp_exp = exp_new;
    check({tag, "_disp"}, 64'(OUT_SEG_ALL), 64'(disp_exp));
  endtask

  initial begin
    RESETN     = 1'b0;
    IN_VALID   = 1'b0;
    IN_FIELDS  = '0;
    BLINK_MASK = '0;
    disp_exp   = ALL_ZERO;
    #12;
    check("rst_disp",  64'(OUT_SEG_ALL), 64'(ALL_ZERO));
    check("rst_ready", 64'(IN_READY), 64'd1);
    check("rst_com",   64'(OUT_COM), 64'd1);
    check("rst_seg",   64'(OUT_SEG), 64'd0);
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    cyc    = 0;

    // 1: scan walk 1,2,4,8,16,32,1 every SD cycles
    for (int i = 0; i < 28; i++) begin
      tick();
      check_scan("walk");
    end

    // 2: nominal transfer {23,59,7}
    transfer("t23_59_7", {7'd7, 7'd59, 7'd23}, 48'h3F07_6D6F_5B4F, 1'b0);

    // 3: overflow field plus 99 and single digit boundaries
    transfer("t127_5_99", {7'd99, 7'd5, 7'd127}, 48'h6F6F_3F6D_4040, 1'b0);

    // 4: IN_VALID while busy is ignored
    transfer("t12_34_56", {7'd56, 7'd34, 7'd12}, 48'h6D7D_4F66_065B, 1'b1);
    for (int i = 0; i < 30; i++) tick();
    check("ignore_disp",  64'(OUT_SEG_ALL), 64'(disp_exp));
    check("ignore_ready", 64'(IN_READY), 64'd1);

    // 5: blink field 1 (digits 2,3)
    BLINK_MASK = 3'b010;
    tick();
    for (int i = 0; i < 48; i++) begin
      tick();
      check_scan("blink");
    end
    BLINK_MASK = 3'b000;
    tick();
    check_scan("noblink");

    // 6: reset during STORE of field 1
    IN_FIELDS = {7'd11, 7'd22, 7'd33};
    IN_VALID  = 1'b1;
    tick();
    IN_VALID = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("pre_rst_busy", 64'(IN_READY), 64'd0);
    RESETN = 1'b0;
    #1;
    check("midrst_disp",  64'(OUT_SEG_ALL), 64'(ALL_ZERO));
    check("midrst_ready", 64'(IN_READY), 64'd1);
    check("midrst_com",   64'(OUT_COM), 64'd1);
    check("midrst_seg",   64'(OUT_SEG), 64'd0);
    @(posedge CLK);
    #1;
    RESETN   = 1'b1;
    cyc      = 0;
    disp_exp = ALL_ZERO;
    check("rel_ready", 64'(IN_READY), 64'd1);
    for (int i = 0; i < 30; i++) begin
      tick();
      check_scan("post_rst");
    end
    check("post_rst_disp",  64'(OUT_SEG_ALL), 64'(ALL_ZERO));
    check("post_rst_ready", 64'(IN_READY), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
